// File: rtl/rv32_core_wait.sv
// Multi-cycle RV32I/RV32E core on a shared req/ack bus with wait states, one transaction in flight.
// Define RV_CORE_HALT_EN to build the Halt state (ecall/ebreak and unknown opcodes stop the core).
module rv32_core_wait #(
   parameter int          ADDR_WIDTH = 30,
   parameter int unsigned RESET_PC   = 0,
   parameter int          NUM_REGS   = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_req,
   input  logic                  bus_ack,
   input  logic [31:0]           bus_data_r,
   output logic [31:0]           bus_data_w,
   output logic [3:0]            bus_mask_w,
   output logic                  halted
);

   localparam int RW = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
   localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_EXEC  = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_STORE = 3'd3;
`ifdef RV_CORE_HALT_EN
   localparam logic [2:0] S_HALT  = 3'd4;
`endif

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_FENCE  = 5'b00011;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   logic [2:0]            state;
   logic [31:0]           ir;
   logic [ADDR_WIDTH-1:0] pc;
   logic [2:0]            ld_f3;
   logic [RW-1:0]         ld_rd;
   logic [1:0]            ld_align;
   logic [31:0]           rf [NUM_REGS];

   logic [4:0]            opcode;
   logic [2:0]            f3;
   logic [RW-1:0]         rd_i, rs1_i, rs2_i;
   logic [31:0]           rs1_v, rs2_v;
   logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0]           pc_byte, link, jal_t, jalr_t, br_t, mem_addr;
   logic [ADDR_WIDTH-1:0] pc_inc;

   assign opcode  = ir[6:2];
   assign f3      = ir[14:12];
   assign rd_i    = ir[7 +: RW];
   assign rs1_i   = ir[15 +: RW];
   assign rs2_i   = ir[20 +: RW];
   assign rs1_v   = (rs1_i == '0) ? 32'd0 : rf[rs1_i];
   assign rs2_v   = (rs2_i == '0) ? 32'd0 : rf[rs2_i];

   assign imm_i   = {{20{ir[31]}}, ir[31:20]};
   assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u   = {ir[31:12], 12'd0};
   assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   assign pc_inc   = pc + PC_ONE;
   assign pc_byte  = 32'({pc, 2'b00});
   assign link     = 32'({pc_inc, 2'b00});
   assign jal_t    = pc_byte + imm_j;
   assign jalr_t   = (rs1_v + imm_i) & 32'hFFFF_FFFE;
   assign br_t     = pc_byte + imm_b;
   assign mem_addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);

   function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                       input logic alt, input logic sub);
      case (f)
         3'b000:  alu = sub ? a - b : a + b;
         3'b001:  alu = a << b[4:0];
         3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
         3'b011:  alu = {31'd0, a < b};
         3'b100:  alu = a ^ b;
         3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  alu = a | b;
         default: alu = a & b;
      endcase
   endfunction

   function automatic logic taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'b000:  taken = (a == b);
         3'b001:  taken = (a != b);
         3'b100:  taken = $signed(a) <  $signed(b);
         3'b101:  taken = $signed(a) >= $signed(b);
         3'b110:  taken = a <  b;
         3'b111:  taken = a >= b;
         default: taken = 1'b0;
      endcase
   endfunction

   logic                  ex_wr, ex_load, ex_store;
   logic [31:0]           ex_wdata;
   logic [ADDR_WIDTH-1:0] ex_next;
`ifdef RV_CORE_HALT_EN
   logic                  ex_halt;
`endif

   always_comb begin
      ex_wr    = 1'b0;
      ex_wdata = 32'd0;
      ex_next  = pc_inc;
      ex_load  = 1'b0;
      ex_store = 1'b0;
`ifdef RV_CORE_HALT_EN
      ex_halt  = 1'b0;
`endif
      if (ir[1:0] == 2'b11) begin
         case (opcode)
            OP_LUI:    begin ex_wr = 1'b1; ex_wdata = imm_u; end
            OP_AUIPC:  begin ex_wr = 1'b1; ex_wdata = pc_byte + imm_u; end
            OP_IMM:    begin ex_wr = 1'b1; ex_wdata = alu(f3, rs1_v, imm_i, ir[30], 1'b0); end
            OP_OP:     begin ex_wr = 1'b1; ex_wdata = alu(f3, rs1_v, rs2_v, ir[30], ir[30]); end
            OP_JAL:    begin ex_wr = 1'b1; ex_wdata = link; ex_next = jal_t[ADDR_WIDTH+1:2]; end
            OP_JALR:   begin ex_wr = 1'b1; ex_wdata = link; ex_next = jalr_t[ADDR_WIDTH+1:2]; end
            OP_BRANCH: begin
               if (taken(f3, rs1_v, rs2_v)) ex_next = br_t[ADDR_WIDTH+1:2];
            end
            OP_LOAD:   ex_load  = 1'b1;
            OP_STORE:  ex_store = 1'b1;
            OP_FENCE:  begin end
            OP_SYSTEM: begin
`ifdef RV_CORE_HALT_EN
               ex_halt = (f3 == 3'b000);
`endif
            end
            default:   begin
`ifdef RV_CORE_HALT_EN
               ex_halt = 1'b1;
`endif
            end
         endcase
      end else begin
`ifdef RV_CORE_HALT_EN
         ex_halt = 1'b1;
`endif
      end
   end

   // Store lanes: shifting a 4-bit mask in 4-bit context drops lanes past byte 3.
   logic [3:0]  st_base, st_mask;
   logic [31:0] st_data;
   always_comb begin
      case (f3[1:0])
         2'b00:   st_base = 4'b0001;
         2'b01:   st_base = 4'b0011;
         default: st_base = 4'b1111;
      endcase
      st_mask = st_base << mem_addr[1:0];
      st_data = rs2_v << {mem_addr[1:0], 3'b000};
   end

   logic [31:0] ld_sh, ld_val;
   always_comb begin
      ld_sh = bus_data_r >> {ld_align, 3'b000};
      case (ld_f3)
         3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
         3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
         3'b100:  ld_val = {24'd0, ld_sh[7:0]};
         3'b101:  ld_val = {16'd0, ld_sh[15:0]};
         default: ld_val = ld_sh;
      endcase
   end

   logic          rf_we;
   logic [RW-1:0] rf_wa;
   logic [31:0]   rf_wd;
   assign rf_we = !reset && ((state == S_EXEC && ex_wr) || (state == S_LOAD && bus_ack));
   assign rf_wa = (state == S_LOAD) ? ld_rd : rd_i;
   assign rf_wd = (state == S_LOAD) ? ld_val : ex_wdata;

   always_ff @(posedge clock) begin
      if (rf_we && rf_wa != '0) rf[rf_wa] <= rf_wd;
   end

   // Reset masks the request so no spurious transaction is shown while the state sits at Fetch.
   assign bus_req = !reset && (state == S_FETCH || state == S_LOAD || state == S_STORE);

`ifdef RV_CORE_HALT_EN
   assign halted = (state == S_HALT);
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= PC_INIT;
         bus_addr   <= PC_INIT;
         bus_mask_w <= 4'd0;
         bus_data_w <= 32'd0;
         ir         <= 32'd0;
         ld_f3      <= 3'd0;
         ld_rd      <= '0;
         ld_align   <= 2'd0;
      end else begin
         case (state)
            S_FETCH: if (bus_ack) begin
               ir    <= bus_data_r;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (ex_load) begin
                  ld_f3    <= f3;
                  ld_rd    <= rd_i;
                  ld_align <= mem_addr[1:0];
                  bus_addr <= mem_addr[ADDR_WIDTH+1:2];
                  state    <= S_LOAD;
               end else if (ex_store) begin
                  bus_mask_w <= st_mask;
                  bus_data_w <= st_data;
                  bus_addr   <= mem_addr[ADDR_WIDTH+1:2];
                  state      <= S_STORE;
`ifdef RV_CORE_HALT_EN
               end else if (ex_halt) begin
                  state <= S_HALT;
`endif
               end else begin
                  pc       <= ex_next;
                  bus_addr <= ex_next;
                  state    <= S_FETCH;
               end
            end
            S_LOAD: if (bus_ack) begin
               pc       <= pc_inc;
               bus_addr <= pc_inc;
               state    <= S_FETCH;
            end
            S_STORE: if (bus_ack) begin
               bus_mask_w <= 4'd0;
               pc         <= pc_inc;
               bus_addr   <= pc_inc;
               state      <= S_FETCH;
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_core_wait.sv
// Directed bench for rv32_core_wait: a small program in a bench memory, every bus transaction
// checked against a hand-computed plan of address, mask, data and latency.
module tb_rv32_core_wait;

   logic        clock = 1'b0;
   logic        reset;
   logic [29:0] bus_addr;
   logic        bus_req;
   logic        bus_ack;
   logic [31:0] bus_data_r;
   logic [31:0] bus_data_w;
   logic [3:0]  bus_mask_w;
   logic        halted;

   logic [31:0] mem [256];
   int          n_compared   = 0;
   int          n_mismatched = 0;

   rv32_core_wait #(.ADDR_WIDTH(30), .RESET_PC(32'h10), .NUM_REGS(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus_addr   (bus_addr),
      .bus_req    (bus_req),
      .bus_ack    (bus_ack),
      .bus_data_r (bus_data_r),
      .bus_data_w (bus_data_w),
      .bus_mask_w (bus_mask_w),
      .halted     (halted)
   );

   always #5 clock = ~clock;

   assign bus_data_r = mem[bus_addr[7:0]];

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      logic [31:0] v;
      v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(int imm20, int rd, int op);
      logic [31:0] v;
      v = imm20;
      return {v[19:0], 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to the next negedge where a handshake is pending; n counts negedges waited.
   task automatic next_txn(output logic [29:0] a, output logic [3:0] m, output logic [31:0] d,
                           output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(bus_req && bus_ack) && n < 50);
      a = bus_addr;
      m = bus_mask_w;
      d = bus_data_w;
   endtask

   task automatic expect_txn(input string tag, input logic [29:0] ea, input logic [3:0] em,
                             input logic [31:0] ed, input int ecyc);
      logic [29:0] a;
      logic [3:0]  m;
      logic [31:0] d;
      int          n;
      next_txn(a, m, d, n);
      check_eq({tag, " addr"}, 32'(a), 32'(ea));
      check_eq({tag, " mask"}, 32'(m), 32'(em));
      if (em != 4'd0) check_eq({tag, " data"}, d, ed);
      check_eq({tag, " latency"}, 32'(n), 32'(ecyc));
   endtask

   typedef struct {
      logic [29:0] a;
      logic [3:0]  m;
      logic [31:0] d;
      int          c;
   } txn_t;

   txn_t plan [$];

   task automatic add(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d, input int c);
      txn_t t;
      t.a = a; t.m = m; t.d = d; t.c = c;
      plan.push_back(t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic saw_req, saw_run;

      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[8'h10] = enc_i(5, 0, 0, 1, 'h13);          // addi x1,x0,5
      mem[8'h11] = enc_i(256, 0, 0, 2, 'h13);        // addi x2,x0,0x100
      mem[8'h12] = enc_u(1, 3, 'h37);                // lui  x3,1
      mem[8'h13] = enc_i('h234, 3, 0, 3, 'h13);      // addi x3,x3,0x234
      mem[8'h14] = enc_s(2, 3, 2, 1);                // sh   x3,2(x2)
      mem[8'h15] = enc_i(1, 2, 0, 4, 'h03);          // lb   x4,1(x2)
      mem[8'h16] = enc_i(1, 2, 4, 5, 'h03);          // lbu  x5,1(x2)
      mem[8'h17] = enc_s(4, 4, 2, 2);                // sw   x4,4(x2)
      mem[8'h18] = enc_s(8, 5, 2, 2);                // sw   x5,8(x2)
      mem[8'h19] = enc_s(12, 1, 2, 2);               // sw   x1,12(x2)
      mem[8'h1A] = enc_r('h20, 3, 1, 0, 6);          // sub  x6,x1,x3
      mem[8'h1B] = enc_i('h404, 4, 5, 7, 'h13);      // srai x7,x4,4
      mem[8'h1C] = enc_r(0, 3, 1, 3, 8);             // sltu x8,x1,x3
      mem[8'h1D] = enc_s(16, 6, 2, 2);
      mem[8'h1E] = enc_s(20, 7, 2, 2);
      mem[8'h1F] = enc_s(24, 8, 2, 2);
      mem[8'h20] = enc_j(-128, 9);                   // jal  x9, word 0
      mem[8'h00] = enc_s(28, 9, 2, 2);               // sw   x9,28(x2)
      mem[8'h01] = enc_b(-8, 0, 0, 0);               // beq  x0,x0 -> byte 0xFFFFFFFC
      mem[8'hFF] = enc_j(12, 0);                     // jal  x0 -> wraps to word 2
      mem[8'h02] = enc_b(-4, 0, 0, 1);               // bne  x0,x0 not taken
      mem[8'h03] = enc_j(8, 0);                      // jal  x0 -> word 5
      mem[8'h05] = 32'h0010_0073;                    // ebreak
      mem[8'h06] = enc_j(0, 0);
      mem[8'h40] = 32'h0000_80FF;

      // ---------------- reset (ack held high, must be ignored) ----------------
      reset   = 1'b1;
      bus_ack = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_eq("reset bus_req", 32'(bus_req), 32'd0);
      check_eq("reset bus_mask_w", 32'(bus_mask_w), 32'd0);
      check_eq("reset bus_data_w", bus_data_w, 32'd0);
      check_eq("reset bus_addr", 32'(bus_addr), 32'h10);
      check_eq("reset halted", 32'(halted), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;

      // First fetch at RESET_PC, next fetch two cycles later.
      expect_txn("fetch 0x10", 30'h10, 4'd0, 32'd0, 1);
      expect_txn("fetch 0x11", 30'h11, 4'd0, 32'd0, 2);

      // Three wait cycles on the fetch of 0x12.
      @(posedge clock);
      #1 bus_ack = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus_req && n < 20);
      check_eq("stall latency", 32'(n), 32'd2);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("stall req c%0d", k), 32'(bus_req), 32'd1);
         check_eq($sformatf("stall addr c%0d", k), 32'(bus_addr), 32'h12);
         check_eq($sformatf("stall mask c%0d", k), 32'(bus_mask_w), 32'd0);
         if (k < 3) @(negedge clock);
      end
      bus_ack = 1'b1;

      add(30'h13, 4'd0, 32'd0, 2);
      add(30'h14, 4'd0, 32'd0, 2);
      add(30'h40, 4'b1100, 32'h1234_0000, 2);        // sh at byte offset 2
      add(30'h15, 4'd0, 32'd0, 1);                   // mask back to 0
      add(30'h40, 4'd0, 32'd0, 2);                   // lb
      add(30'h16, 4'd0, 32'd0, 1);
      add(30'h40, 4'd0, 32'd0, 2);                   // lbu
      add(30'h17, 4'd0, 32'd0, 1);
      add(30'h41, 4'b1111, 32'hFFFF_FF80, 2);        // lb sign-extended
      add(30'h18, 4'd0, 32'd0, 1);
      add(30'h42, 4'b1111, 32'h0000_0080, 2);        // lbu zero-extended
      add(30'h19, 4'd0, 32'd0, 1);
      add(30'h43, 4'b1111, 32'd5, 2);                // x1
      add(30'h1A, 4'd0, 32'd0, 1);
      add(30'h1B, 4'd0, 32'd0, 2);
      add(30'h1C, 4'd0, 32'd0, 2);
      add(30'h1D, 4'd0, 32'd0, 2);
      add(30'h44, 4'b1111, 32'hFFFF_EDD1, 2);        // 5 - 0x1234
      add(30'h1E, 4'd0, 32'd0, 1);
      add(30'h45, 4'b1111, 32'hFFFF_FFF8, 2);        // 0xFFFFFF80 >>> 4
      add(30'h1F, 4'd0, 32'd0, 1);
      add(30'h46, 4'b1111, 32'd1, 2);                // sltu
      add(30'h20, 4'd0, 32'd0, 1);
      add(30'h00, 4'd0, 32'd0, 2);                   // jal back to word 0
      add(30'h47, 4'b1111, 32'h0000_0084, 2);        // link = byte 0x84
      add(30'h01, 4'd0, 32'd0, 1);
      add(30'h3FFF_FFFF, 4'd0, 32'd0, 2);            // taken beq wraps below 0
      add(30'h02, 4'd0, 32'd0, 2);                   // jal wraps back up
      add(30'h03, 4'd0, 32'd0, 2);                   // bne not taken
      add(30'h05, 4'd0, 32'd0, 2);                   // ebreak fetch
      foreach (plan[i]) expect_txn($sformatf("txn%0d", i), plan[i].a, plan[i].m, plan[i].d, plan[i].c);

`ifdef RV_CORE_HALT_EN
      @(negedge clock);
      saw_req = 1'b0;
      saw_run = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (bus_req) saw_req = 1'b1;
         if (!halted) saw_run = 1'b1;
      end
      check_eq("halt bus_req seen", 32'(saw_req), 32'd0);
      check_eq("halt halted dropped", 32'(saw_run), 32'd0);
`else
      saw_req = 1'b0;
      saw_run = 1'b0;
      expect_txn("fetch after ebreak", 30'h06, 4'd0, 32'd0, 2);
      check_eq("halted tied low", 32'(halted), 32'd0);
      check_eq("halt flags", 32'({saw_req, saw_run}), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
